// File: rtl/fifo_drain_byte_ctrl.sv
// Read-side sequencer: pops 48-bit FIFO words and streams them MSB-first as bytes.
// Optional FIFO_SYNC_HDR_EN prepends SYNC_BYTE to every word.
module fifo_drain_byte_ctrl #(
    parameter int unsigned DATA_W    = 48,
    parameter int unsigned NBYTES    = DATA_W / 8,
    parameter int unsigned CNT_W     = 6,
    parameter int unsigned BURST_MIN = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [15:0]       words_sent
);

    localparam int unsigned IDX_W = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {S_IDLE, S_POP, S_CAP, S_SEND, S_NEXT} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   shift;
    logic [IDX_W-1:0]    idx;
    logic                hdr;
    logic                start, more, accept, last;

    assign start  = enable && !fifo_empty && ((fifo_count >= CNT_W'(BURST_MIN)) || flush);
    assign more   = enable && !fifo_empty;
    assign accept = (state == S_SEND) && tx_ready;
    assign last   = !hdr && (idx == IDX_W'(NBYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_POP;
            end
            S_POP: begin
                fifo_rd_en = 1'b1;
                state_nxt  = S_CAP;
            end
            S_CAP:  state_nxt = S_SEND;
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = hdr ? SYNC_BYTE : shift[DATA_W-1 -: 8];
                if (tx_ready && last) state_nxt = S_NEXT;
            end
            S_NEXT: state_nxt = more ? S_POP : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Header flag is a constant 0 in the default build, so SEND muxes straight to data.
`ifdef FIFO_SYNC_HDR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 hdr <= 1'b0;
        else if (state == S_CAP) hdr <= 1'b1;
        else if (accept)         hdr <= 1'b0;
    end
`else
    assign hdr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift      <= '0;
            idx        <= '0;
            words_sent <= '0;
        end else if (state == S_CAP) begin
            shift <= fifo_dout;
            idx   <= '0;
        end else if (accept && !hdr) begin
            shift <= shift << 8;
            idx   <= idx + 1'b1;
            if (last) words_sent <= words_sent + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_drain_byte_ctrl.sv
// Self-checking bench: emulated FIFO, byte-stream reference model, per-cycle protocol checks.
module tb_fifo_drain_byte_ctrl;

    localparam int NB = 6;
`ifdef FIFO_SYNC_HDR_EN
    localparam int HOFF = 1;
`else
    localparam int HOFF = 0;
`endif
    localparam int BPW = NB + HOFF;

    logic        clk = 1'b0;
    logic        rst, enable, flush, tx_ready;
    logic        fifo_empty = 1'b1;
    logic [5:0]  fifo_count = '0;
    logic [47:0] fifo_dout  = '0;
    logic        fifo_rd_en, tx_valid, busy;
    logic [7:0]  tx_data;
    logic [15:0] words_sent;

    logic        wr_en;
    logic [47:0] wr_word;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_drain_byte_ctrl #(.DATA_W(48), .CNT_W(6), .BURST_MIN(4), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .words_sent(words_sent)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // FIFO emulator; popped words are logged for the reference model
    logic [47:0] fq [$];
    logic [47:0] popw [256];
    logic [7:0]  wi = '0;
    int          pops = 0;

    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            fifo_dout <= fq[0];
            popw[wi]  = fq.pop_front();
            wi        = wi + 8'd1;
            pops++;
        end
        if (wr_en) fq.push_back(wr_word);
        fifo_count <= 6'(fq.size());
        fifo_empty <= (fq.size() == 0);
    end

    // Reference model: byte stream = popped words, MSB first, optional header each word
    logic [7:0]  ri = '0;
    int          pos = 0;
    logic [15:0] words_done = '0;
    logic [7:0]  seen [$];
    bit          dec_pend = 0, exp_rd = 0, in_next = 0, prev_stall = 0, prev_rd = 0;
    int          val_due = 0;
    logic [7:0]  prev_data = '0;

    always @(negedge clk) begin
        logic [47:0] w;
        logic [7:0]  eb;
        if (rst) begin
            check("rst_rd_en", fifo_rd_en, 0);
            check("rst_tx_valid", tx_valid, 0);
            check("rst_tx_data", tx_data, 0);
            check("rst_busy", busy, 0);
            check("rst_words", words_sent, 0);
            ri = wi; pos = 0; words_done = '0;
            dec_pend = 0; in_next = 0; prev_stall = 0; prev_rd = 0; val_due = 0;
        end else begin
            check("words_sent", words_sent, words_done);
            if (fifo_rd_en) begin
                check("rd_when_empty", fifo_empty, 0);
                check("rd_back_to_back", prev_rd, 0);
            end
            if (dec_pend) begin
                check("decide_rd", fifo_rd_en, exp_rd);
                check("decide_busy", busy, exp_rd);
                dec_pend = 0;
            end
            if (val_due > 0) begin
                val_due--;
                if (val_due == 0) check("first_valid", tx_valid, 1);
                else              check("cap_no_valid", tx_valid, 0);
            end
            if (fifo_rd_en) val_due = 2;
            if (prev_stall) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, prev_data);
            end
            if (!busy) begin
                dec_pend = 1;
                exp_rd   = enable && !fifo_empty && (fifo_count >= 6'd4 || flush);
            end else if (in_next) begin
                dec_pend = 1;
                exp_rd   = enable && !fifo_empty;
            end
            in_next = 0;
            if (tx_valid && tx_ready) begin
                seen.push_back(tx_data);
                if (ri == wi) begin
                    check("byte_without_pop", 1, 0);
                end else begin
                    w  = popw[ri];
                    eb = (pos < HOFF) ? 8'hA5 : 8'(w >> (8 * (NB - 1 - (pos - HOFF))));
                    check("tx_byte", tx_data, eb);
                    pos++;
                    if (pos == BPW) begin
                        pos = 0; ri = ri + 8'd1; words_done = words_done + 16'd1; in_next = 1;
                    end
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_rd    = fifo_rd_en;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [47:0] w);
        wr_en = 1'b1; wr_word = w;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1; tick(1); flush = 1'b0;
    endtask

    task automatic drain(input string nm, input int limit);
        int n = 0;
        while (!(fifo_empty && !busy) && n < limit) begin tick(1); n++; end
        check(nm, fifo_empty && !busy, 1);
    endtask

    task automatic check_bytes(input string nm, input int base, input logic [47:0] w, input bit hdr);
        int k = 0;
        logic [7:0] lit [$];
        if (hdr) lit.push_back(8'hA5);
        for (int i = NB - 1; i >= 0; i--) lit.push_back(8'(w >> (8 * i)));
        if (seen.size() < base + lit.size()) begin
            check(nm, seen.size(), base + lit.size());
        end else begin
            foreach (lit[i]) begin
                check(nm, seen[base + k], lit[i]);
                k++;
            end
        end
    endtask

    initial begin
        int base;
        int n;
        rst = 1'b1; enable = 1'b0; flush = 1'b0; tx_ready = 1'b0;
        wr_en = 1'b0; wr_word = '0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // 1: three words below threshold, no flush -> stays idle
        enable = 1'b1;
        base = seen.size();
        push(48'h0102_0304_0506);
        push(48'h1111_2222_3333);
        push(48'h4444_5555_6666);
        tick(20);
        check("t1_no_pop", pops, 0);
        check("t1_idle", busy, 0);

        // 2: fourth word reaches threshold; whole burst drains
        tx_ready = 1'b1;
        push(48'h7777_8888_9999);
        drain("t2_drain", 200);
        check("t2_words", words_sent, 4);
        check("t2_pops", pops, 4);
        check_bytes("t2_first_word", base, 48'h0102_0304_0506, HOFF == 1);

        // 3: single word, one-cycle flush
        push(48'hDEAD_BEEF_0042);
        tick(2);
        pulse_flush();
        drain("t3_drain", 100);
        check("t3_words", words_sent, 5);

        // 4: stall pattern 1-0-0-1 during SEND
        tx_ready = 1'b0;
        push(48'h1122_3344_5566);
        tick(1);
        pulse_flush();
        n = 0;
        while (!tx_valid && n < 20) begin tick(1); n++; end
        check("t4_valid_seen", tx_valid, 1);
        tx_ready = 1'b1; tick(1);
        tx_ready = 1'b0; tick(1);
        tick(1);
        tx_ready = 1'b1;
        drain("t4_drain", 100);
        check("t4_words", words_sent, 6);

        // 5: reset while byte 3 of a word is on the bus
        for (int i = 0; i < 5; i++) push({16'($urandom), 32'($urandom)});
        n = 0;
        while (!(pos == 3 && tx_valid) && n < 100) begin tick(1); n++; end
        check("t5_reached_byte3", pos == 3 && tx_valid, 1);
        rst = 1'b1;
        #1;
        check("t5_async_valid", tx_valid, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("t5_words_cleared", words_sent, 0);
        drain("t5_drain", 200);
        check("t5_words", words_sent, 4);

`ifdef FIFO_SYNC_HDR_EN
        // 6: header byte precedes data
        base = seen.size();
        push(48'hAABB_CCDD_EEFF);
        tick(2);
        pulse_flush();
        drain("t6_drain", 100);
        check_bytes("t6_bytes", base, 48'hAABB_CCDD_EEFF, 1'b1);
        check("t6_words", words_sent, 5);
`endif

        // random traffic: writes, enable/flush toggles, ready back-pressure
        for (int c = 0; c < 1500; c++) begin
            enable   = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 4) == 0);
            tx_ready = ($urandom_range(0, 9) < 7);
            if (fifo_count < 6'd26 && $urandom_range(0, 9) < 3) begin
                wr_en = 1'b1; wr_word = {16'($urandom), 32'($urandom)};
            end else begin
                wr_en = 1'b0;
            end
            tick(1);
        end
        wr_en = 1'b0; enable = 1'b1; flush = 1'b1; tx_ready = 1'b1;
        drain("final_drain", 3000);
        flush = 1'b0;
        tick(3);
        check("final_idle", busy, 0);
        check("final_backlog", ri, wi);
        check("final_words", words_sent, words_done);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
